// File: rtl/synth_pkg.sv
// Shared constants and types for the voice engine / frame assembler / mixer path.
package synth_pkg;

    localparam int SAMPLE_W   = 32;
    localparam int NUM_VOICES = 16;

    typedef logic [$clog2(NUM_VOICES)-1:0] voice_idx_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } asm_state_t;

endpackage

// File: rtl/voice_frame_assembler_if.sv
// Voice engine -> frame assembler sample handshake (one voice per transfer).
interface voice_frame_assembler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VOICES = 16
) ();

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic signed [DATA_WIDTH-1:0] s_voice_data;
    logic        [IDX_W-1:0]      s_voice_idx;
    logic                         s_valid;
    logic                         s_ready;

    modport master (
        output s_voice_data,
        output s_voice_idx,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_voice_data,
        input  s_voice_idx,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/voice_frame_assembler.sv
// Collects per-voice samples into a shadow frame and publishes it on sample_tick.
// Optional per-voice mute at publish time when VOICE_ASM_MUTE_EN is defined.
module voice_frame_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_VOICES = 16,
    parameter int UNDERRUN_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    voice_frame_assembler_if.slave           voice,
    input  logic                             sample_tick,
`ifdef VOICE_ASM_MUTE_EN
    input  logic [NUM_VOICES-1:0]            voice_mask,
`endif
    output logic [DATA_WIDTH*NUM_VOICES-1:0] voice_out_flat,
    output logic                             data_out_valid,
    output logic                             seq_err,
    output logic [UNDERRUN_W-1:0]            underrun_cnt
);

    import synth_pkg::*;

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    asm_state_t state, state_nxt;

    logic                    armed;
    logic                    ready;
    logic [IDX_W-1:0]        wr_ptr;
    logic [DATA_WIDTH-1:0]   shadow     [NUM_VOICES];
    logic [DATA_WIDTH-1:0]   shadow_nxt [NUM_VOICES];
    logic [DATA_WIDTH*NUM_VOICES-1:0] frame_pub;

    logic accept, idx_ok, restart, drop, last, publish, underrun;

    assign accept   = voice.s_valid && ready;
    assign idx_ok   = accept && (voice.s_voice_idx == wr_ptr);
    assign restart  = accept && (voice.s_voice_idx != wr_ptr) && (voice.s_voice_idx == '0);
    assign drop     = accept && !idx_ok && !restart;
    assign last     = idx_ok && (wr_ptr == LAST_IDX);
    assign publish  = sample_tick && ((state == FULL) || last);
    assign underrun = sample_tick && (state == COLLECT) && !last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (last && !sample_tick) state_nxt = FULL;
            FULL:    if (sample_tick)          state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Output logic; armed holds s_ready low for the first cycle out of reset
    always_comb begin
        ready = armed && (state == COLLECT);
    end

    assign voice.s_ready = ready;

    // Shadow as it will be after this edge, so a same-cycle final sample is published
    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) shadow_nxt[i] = shadow[i];
        if (idx_ok)       shadow_nxt[wr_ptr] = voice.s_voice_data;
        else if (restart) shadow_nxt[0]      = voice.s_voice_data;
    end

    always_comb begin
        frame_pub = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
`ifdef VOICE_ASM_MUTE_EN
            frame_pub[i*DATA_WIDTH +: DATA_WIDTH] = voice_mask[i] ? '0 : shadow_nxt[i];
`else
            frame_pub[i*DATA_WIDTH +: DATA_WIDTH] = shadow_nxt[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) shadow[i] <= '0;
        end else begin
            armed <= 1'b1;
            for (int unsigned i = 0; i < NUM_VOICES; i++) shadow[i] <= shadow_nxt[i];
            if (idx_ok)       wr_ptr <= wr_ptr + 1'b1;
            else if (restart) wr_ptr <= IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_out_flat <= '0;
            data_out_valid <= 1'b0;
            seq_err        <= 1'b0;
            underrun_cnt   <= '0;
        end else begin
            data_out_valid <= publish || underrun;
            seq_err        <= restart || drop;
            if (publish) voice_out_flat <= frame_pub;
            if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_voice_frame_assembler.sv
// Directed self-checking bench for voice_frame_assembler (NUM_VOICES=4, DATA_WIDTH=32).
// Mute checks are compiled in only when VOICE_ASM_MUTE_EN is defined.
module tb_voice_frame_assembler;

    localparam int DW = 32;
    localparam int NV = 4;
    localparam int UW = 16;

    logic              clk;
    logic              rst_n;
    logic              sample_tick;
    logic [DW*NV-1:0]  voice_out_flat;
    logic              data_out_valid;
    logic              seq_err;
    logic [UW-1:0]     underrun_cnt;
`ifdef VOICE_ASM_MUTE_EN
    logic [NV-1:0]     voice_mask;
`endif

    int checks = 0;
    int errors = 0;

    voice_frame_assembler_if #(.DATA_WIDTH(DW), .NUM_VOICES(NV)) vif ();

    voice_frame_assembler #(
        .DATA_WIDTH (DW),
        .NUM_VOICES (NV),
        .UNDERRUN_W (UW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .voice          (vif),
        .sample_tick    (sample_tick),
`ifdef VOICE_ASM_MUTE_EN
        .voice_mask     (voice_mask),
`endif
        .voice_out_flat (voice_out_flat),
        .data_out_valid (data_out_valid),
        .seq_err        (seq_err),
        .underrun_cnt   (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int unsigned i);
        return voice_out_flat[i*DW +: DW];
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned idx, input logic [31:0] data, input logic tick);
        check("ready_before_push", {31'b0, vif.s_ready}, 32'd1);
        vif.s_valid      = 1'b1;
        vif.s_voice_idx  = idx[1:0];
        vif.s_voice_data = data;
        sample_tick      = tick;
        step();
        vif.s_valid = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] v3);
        check({tag, "_s0"}, slice(0), v0);
        check({tag, "_s1"}, slice(1), v1);
        check({tag, "_s2"}, slice(2), v2);
        check({tag, "_s3"}, slice(3), v3);
    endtask

    initial begin
        rst_n            = 1'b0;
        sample_tick      = 1'b0;
        vif.s_valid      = 1'b0;
        vif.s_voice_idx  = '0;
        vif.s_voice_data = '0;
`ifdef VOICE_ASM_MUTE_EN
        voice_mask       = '0;
`endif
        repeat (3) step();

        check_frame("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        check("rst_valid", {31'b0, data_out_valid}, 32'd0);
        check("rst_seq_err", {31'b0, seq_err}, 32'd0);
        check("rst_underrun", {16'b0, underrun_cnt}, 32'd0);
        check("rst_ready", {31'b0, vif.s_ready}, 32'd0);

        rst_n = 1'b1;
        #1;
        check("ready_held_after_release", {31'b0, vif.s_ready}, 32'd0);
        step();
        check("ready_after_first_clk", {31'b0, vif.s_ready}, 32'd1);

        // In-order frame
        push(0, 32'd10, 1'b0);
        push(1, 32'd20, 1'b0);
        push(2, -32'sd30, 1'b0);
        push(3, 32'd40, 1'b0);
        check("full_ready_low", {31'b0, vif.s_ready}, 32'd0);
        check("full_no_valid", {31'b0, data_out_valid}, 32'd0);
        step();
        check("full_ready_still_low", {31'b0, vif.s_ready}, 32'd0);
        check_frame("pre_publish", 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("pub1_valid", {31'b0, data_out_valid}, 32'd1);
        check_frame("pub1", 32'd10, 32'd20, 32'hFFFF_FFE2, 32'd40);
        step();
        check("pub1_valid_pulse", {31'b0, data_out_valid}, 32'd0);
        check("pub1_ready_back", {31'b0, vif.s_ready}, 32'd1);
        check("pub1_underrun", {16'b0, underrun_cnt}, 32'd0);

        // Final sample accepted in the tick cycle
        push(0, 32'd1, 1'b0);
        push(1, 32'd2, 1'b0);
        push(2, 32'd3, 1'b0);
        push(3, 32'd4, 1'b1);
        check("same_cyc_valid", {31'b0, data_out_valid}, 32'd1);
        check_frame("same_cyc", 32'd1, 32'd2, 32'd3, 32'd4);
        check("same_cyc_underrun", {16'b0, underrun_cnt}, 32'd0);
        check("same_cyc_ready", {31'b0, vif.s_ready}, 32'd1);

        // Underrun repeats previous frame, collection continues
        push(0, 32'd100, 1'b0);
        push(1, 32'd200, 1'b0);
        tick();
        check("ur_valid", {31'b0, data_out_valid}, 32'd1);
        check_frame("ur_repeat", 32'd1, 32'd2, 32'd3, 32'd4);
        check("ur_cnt", {16'b0, underrun_cnt}, 32'd1);
        push(2, 32'd300, 1'b0);
        push(3, 32'd400, 1'b0);
        tick();
        check("ur_next_valid", {31'b0, data_out_valid}, 32'd1);
        check_frame("ur_next", 32'd100, 32'd200, 32'd300, 32'd400);
        check("ur_cnt_hold", {16'b0, underrun_cnt}, 32'd1);
        step();

        // Sequence errors: drop, then restart
        push(0, 32'd5, 1'b0);
        check("seq_ok", {31'b0, seq_err}, 32'd0);
        push(2, 32'd7, 1'b0);
        check("seq_drop_pulse", {31'b0, seq_err}, 32'd1);
        step();
        check("seq_drop_one_cycle", {31'b0, seq_err}, 32'd0);
        push(1, 32'd6, 1'b0);
        check("seq_ptr_kept", {31'b0, seq_err}, 32'd0);
        push(0, 32'd9, 1'b0);
        check("seq_restart_pulse", {31'b0, seq_err}, 32'd1);
        push(1, 32'd11, 1'b0);
        push(2, 32'd12, 1'b0);
        push(3, 32'd13, 1'b0);
        check("seq_full", {31'b0, vif.s_ready}, 32'd0);
        tick();
        check_frame("seq_pub", 32'd9, 32'd11, 32'd12, 32'd13);
        step();

        // Asynchronous reset mid-frame
        push(0, 32'd50, 1'b0);
        push(1, 32'd51, 1'b0);
        push(2, 32'd52, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_frame("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
        check("mid_rst_underrun", {16'b0, underrun_cnt}, 32'd0);
        check("mid_rst_ready", {31'b0, vif.s_ready}, 32'd0);
        check("mid_rst_valid", {31'b0, data_out_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        push(0, 32'd21, 1'b0);
        push(1, 32'd22, 1'b0);
        push(2, 32'd23, 1'b0);
        push(3, 32'd24, 1'b0);
        tick();
        check("post_rst_valid", {31'b0, data_out_valid}, 32'd1);
        check_frame("post_rst", 32'd21, 32'd22, 32'd23, 32'd24);
        check("post_rst_underrun", {16'b0, underrun_cnt}, 32'd0);
        step();

`ifdef VOICE_ASM_MUTE_EN
        push(0, 32'd31, 1'b0);
        push(1, 32'd32, 1'b0);
        push(2, 32'd33, 1'b0);
        push(3, 32'd34, 1'b0);
        voice_mask = 4'b0101;
        tick();
        voice_mask = 4'b0000;
        check_frame("mute", 32'd0, 32'd32, 32'd0, 32'd34);
        tick();
        check_frame("mute_repeat", 32'd0, 32'd32, 32'd0, 32'd34);
        check("mute_repeat_underrun", {16'b0, underrun_cnt}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`endif

        // Underrun counter saturation: tick every cycle with no samples
        sample_tick = 1'b1;
        repeat (65534) step();
        check("sat_below", {16'b0, underrun_cnt}, 32'h0000_FFFE);
        repeat (7) step();
        sample_tick = 1'b0;
        check("sat_hold", {16'b0, underrun_cnt}, 32'h0000_FFFF);
        check("sat_valid", {31'b0, data_out_valid}, 32'd1);
`ifdef VOICE_ASM_MUTE_EN
        check_frame("sat_frame", 32'd0, 32'd0, 32'd0, 32'd0);
`else
        check_frame("sat_frame", 32'd21, 32'd22, 32'd23, 32'd24);
`endif
        step();
        check("sat_valid_drop", {31'b0, data_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
